bp_unit_param: RTL and testbench

- Parametrised branch prediction unit: BHT of saturating counters plus tagged BTB, with selectable bimodal or gshare indexing and speculative global history with mispredict recovery.
- Sits beside IF. Lookup is combinational on the fetch PC; updates arrive from the resolving stage.
- Supersedes the fixed 2-bit, fixed-depth predictor inside the datapath.

---
 rtl/bp_pkg.sv | 35 +++
 rtl/bp_unit_param_if.sv | 33 +++
 rtl/bp_table.sv | 53 +++++
 rtl/bp_unit_param.sv | 162 ++++++++++++++++
 tb/tb_bp_unit_param.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch prediction unit: FSM state,
// counter init value, and the table index / BTB tag extraction functions.
package bp_pkg;

    typedef enum logic {
        INIT,
        READY
    } bp_state_e;

    // Weakly not-taken: one below the counter midpoint.
    function automatic int ctr_init(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

    // Word-aligned PC bits select the entry; gshare folds history in.
    function automatic logic [31:0] bp_index(
        input logic [63:0] pc,
        input logic [31:0] hist,
        input int          mode,
        input int          idx_w
    );
        logic [31:0] base;
        base = 32'(pc >> 2) & ((32'd1 << idx_w) - 32'd1);
        return (mode == 1) ? (base ^ hist) : base;
    endfunction

    function automatic logic [31:0] bp_tag(
        input logic [63:0] pc,
        input int          idx_w,
        input int          tag_w
    );
        return 32'(pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1);
    endfunction

endpackage

// File: rtl/bp_unit_param_if.sv
// Fetch-lookup and resolve-update bundle of the branch predictor.
// master: pipeline side (drives lookup/update); slave: predictor.
interface bp_unit_param_if #(
    parameter int XLEN  = 32,
    parameter int GHR_W = 6
);
    logic             lookup_valid;
    logic [XLEN-1:0]  lookup_pc;
    logic             pred_hit;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic [GHR_W-1:0] pred_ghr;
    logic             upd_valid;
    logic [XLEN-1:0]  upd_pc;
    logic             upd_taken;
    logic [XLEN-1:0]  upd_target;
    logic             upd_mispredict;
    logic [GHR_W-1:0] upd_ghr;

    modport master (
        output lookup_valid, lookup_pc,
        output upd_valid, upd_pc, upd_taken,
        output upd_target, upd_mispredict, upd_ghr,
        input  pred_hit, pred_taken, pred_target, pred_ghr
    );

    modport slave (
        input  lookup_valid, lookup_pc,
        input  upd_valid, upd_pc, upd_taken,
        input  upd_target, upd_mispredict, upd_ghr,
        output pred_hit, pred_taken, pred_target, pred_ghr
    );
endinterface

// File: rtl/bp_table.sv
// BHT counters plus BTB valid/tag/target storage.
// Ports: lookup read (counter idx + BTB idx), update-index counter read,
// one write port split into counter and BTB enables.
module bp_table #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2,
    parameter int TAG_W   = 8,
    parameter int IDX_W   = 6
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] lk_cidx,
    input  logic [IDX_W-1:0] lk_bidx,
    output logic [CNT_W-1:0] lk_cnt,
    output logic             lk_valid,
    output logic [TAG_W-1:0] lk_tag,
    output logic [XLEN-1:0]  lk_target,
    input  logic [IDX_W-1:0] up_cidx,
    output logic [CNT_W-1:0] up_cnt,
    input  logic             ctr_we,
    input  logic [IDX_W-1:0] ctr_widx,
    input  logic [CNT_W-1:0] ctr_wdata,
    input  logic             btb_we,
    input  logic [IDX_W-1:0] btb_widx,
    input  logic             btb_wvalid,
    input  logic [TAG_W-1:0] btb_wtag,
    input  logic [XLEN-1:0]  btb_wtarget
);

    logic [CNT_W-1:0] cnt_mem [ENTRIES];
    logic             val_mem [ENTRIES];
    logic [TAG_W-1:0] tag_mem [ENTRIES];
    logic [XLEN-1:0]  tgt_mem [ENTRIES];

    assign lk_cnt    = cnt_mem[lk_cidx];
    assign lk_valid  = val_mem[lk_bidx];
    assign lk_tag    = tag_mem[lk_bidx];
    assign lk_target = tgt_mem[lk_bidx];
    assign up_cnt    = cnt_mem[up_cidx];

    // Contents are established by the init sweep, not by reset.
    always_ff @(posedge clk) begin
        if (ctr_we) begin
            cnt_mem[ctr_widx] <= ctr_wdata;
        end
        if (btb_we) begin
            val_mem[btb_widx] <= btb_wvalid;
            tag_mem[btb_widx] <= btb_wtag;
            tgt_mem[btb_widx] <= btb_wtarget;
        end
    end

endmodule

// File: rtl/bp_unit_param.sv
// Branch predictor: saturating-counter BHT + tagged BTB, bimodal/gshare,
// speculative history with recovery. Ports: clk, rst_n, ready, bus (slave).
// Optional BP_STATS_EN adds stat_lookups/stat_updates/stat_mispred.
module bp_unit_param
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2,
    parameter int TAG_W   = 8,
    parameter int GHR_W   = 6,
    parameter int MODE    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ready,
`ifdef BP_STATS_EN
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispred,
`endif
    bp_unit_param_if.slave bus
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ctr_init(CNT_W));
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    bp_state_e        state_q, state_d;
    logic [IDX_W-1:0] init_idx;
    logic [GHR_W-1:0] ghr, ghr_d;

    logic [IDX_W-1:0] lk_base, lk_idx, up_base, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag, rd_tag;
    logic [CNT_W-1:0] rd_cnt, up_cnt, ctr_next;
    logic             rd_valid;
    logic [XLEN-1:0]  rd_target;

    logic             ctr_we, btb_we, btb_wvalid;
    logic [IDX_W-1:0] ctr_widx, btb_widx;
    logic [CNT_W-1:0] ctr_wdata;
    logic             upd_go;

    assign lk_base = IDX_W'(bp_index(64'(bus.lookup_pc), 32'd0, 0, IDX_W));
    assign lk_idx  = IDX_W'(bp_index(64'(bus.lookup_pc), 32'(ghr), MODE, IDX_W));
    assign lk_tag  = TAG_W'(bp_tag(64'(bus.lookup_pc), IDX_W, TAG_W));
    assign up_base = IDX_W'(bp_index(64'(bus.upd_pc), 32'd0, 0, IDX_W));
    assign up_idx  = IDX_W'(bp_index(64'(bus.upd_pc), 32'(bus.upd_ghr), MODE, IDX_W));
    assign up_tag  = TAG_W'(bp_tag(64'(bus.upd_pc), IDX_W, TAG_W));

    bp_table #(
        .XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W),
        .TAG_W(TAG_W), .IDX_W(IDX_W)
    ) u_table (
        .clk        (clk),
        .lk_cidx    (lk_idx),
        .lk_bidx    (lk_base),
        .lk_cnt     (rd_cnt),
        .lk_valid   (rd_valid),
        .lk_tag     (rd_tag),
        .lk_target  (rd_target),
        .up_cidx    (up_idx),
        .up_cnt     (up_cnt),
        .ctr_we     (ctr_we),
        .ctr_widx   (ctr_widx),
        .ctr_wdata  (ctr_wdata),
        .btb_we     (btb_we),
        .btb_widx   (btb_widx),
        .btb_wvalid (btb_wvalid),
        .btb_wtag   (up_tag),
        .btb_wtarget(bus.upd_target)
    );

    assign ready  = (state_q == READY);
    assign upd_go = ready && bus.upd_valid;

    // Outputs held at their reset values until the sweep completes.
    assign bus.pred_hit    = ready && rd_valid && (rd_tag == lk_tag);
    assign bus.pred_taken  = bus.pred_hit && rd_cnt[CNT_W-1];
    assign bus.pred_target = bus.pred_taken ? rd_target
                                            : bus.lookup_pc + XLEN'(4);
    assign bus.pred_ghr    = ghr;

    always_comb begin
        ctr_next = up_cnt;
        if (bus.upd_taken) begin
            if (up_cnt != CNT_MAX) ctr_next = up_cnt + CNT_W'(1);
        end else begin
            if (up_cnt != '0) ctr_next = up_cnt - CNT_W'(1);
        end
    end

    // Single write port: the init sweep owns it until READY.
    always_comb begin
        ctr_we     = 1'b0;
        ctr_widx   = up_idx;
        ctr_wdata  = ctr_next;
        btb_we     = 1'b0;
        btb_widx   = up_base;
        btb_wvalid = 1'b1;
        if (!ready) begin
            ctr_we     = 1'b1;
            ctr_widx   = init_idx;
            ctr_wdata  = CNT_INIT;
            btb_we     = 1'b1;
            btb_widx   = init_idx;
            btb_wvalid = 1'b0;
        end else if (bus.upd_valid) begin
            ctr_we = 1'b1;
            btb_we = bus.upd_taken;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:    if (init_idx == LAST_IDX) state_d = READY;
            READY:   state_d = READY;
            default: state_d = INIT;
        endcase
    end

    // Mispredict recovery overrides the speculative shift.
    always_comb begin
        ghr_d = ghr;
        if (upd_go && bus.upd_mispredict) begin
            ghr_d = GHR_W'({bus.upd_ghr, bus.upd_taken});
        end else if (ready && bus.lookup_valid && bus.pred_hit) begin
            ghr_d = GHR_W'({ghr, bus.pred_taken});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= INIT;
            init_idx <= '0;
            ghr      <= '0;
        end else begin
            state_q <= state_d;
            ghr     <= ghr_d;
            if (!ready) init_idx <= init_idx + IDX_W'(1);
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lookups <= '0;
            stat_updates <= '0;
            stat_mispred <= '0;
        end else if (ready) begin
            if (bus.lookup_valid) stat_lookups <= stat_lookups + 32'd1;
            if (bus.upd_valid) begin
                stat_updates <= stat_updates + 32'd1;
                if (bus.upd_mispredict) stat_mispred <= stat_mispred + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bp_unit_param.sv
// Bench for bp_unit_param: bimodal and gshare instances driven in lockstep,
// checked every cycle against an array-based model plus directed checks.
module tb_bp_unit_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        lv, uv, ut, um;
    logic [31:0] lpc, upc, utgt;
    logic [5:0]  ughr;
    logic        rdy0, rdy1;

    bp_unit_param_if #(.XLEN(32), .GHR_W(6)) bi0 ();
    bp_unit_param_if #(.XLEN(32), .GHR_W(6)) bi1 ();

    assign bi0.lookup_valid = lv;   assign bi1.lookup_valid = lv;
    assign bi0.lookup_pc    = lpc;  assign bi1.lookup_pc    = lpc;
    assign bi0.upd_valid    = uv;   assign bi1.upd_valid    = uv;
    assign bi0.upd_pc       = upc;  assign bi1.upd_pc       = upc;
    assign bi0.upd_taken    = ut;   assign bi1.upd_taken    = ut;
    assign bi0.upd_target   = utgt; assign bi1.upd_target   = utgt;
    assign bi0.upd_mispredict = um; assign bi1.upd_mispredict = um;
    assign bi0.upd_ghr      = ughr; assign bi1.upd_ghr      = ughr;

`ifdef BP_STATS_EN
    logic [31:0] sl0, su0, sm0, sl1, su1, sm1;
`endif

    bp_unit_param #(.MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ready(rdy0),
`ifdef BP_STATS_EN
        .stat_lookups(sl0), .stat_updates(su0), .stat_mispred(sm0),
`endif
        .bus(bi0)
    );

    bp_unit_param #(.MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ready(rdy1),
`ifdef BP_STATS_EN
        .stat_lookups(sl1), .stat_updates(su1), .stat_mispred(sm1),
`endif
        .bus(bi1)
    );

    int errors = 0;
    int checks = 0;

    int          m_cnt [2][64];
    bit          m_val [2][64];
    int          m_tag [2][64];
    logic [31:0] m_tgt [2][64];
    int          m_ghr [2];
    int          m_sl [2], m_su [2], m_sm [2];
    int          m_init;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int base_of(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'd64);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc / 32'd256) % 32'd256);
    endfunction

    function automatic int pidx(input int m, input logic [31:0] pc,
                                input int h);
        return (m == 1) ? (base_of(pc) ^ h) : base_of(pc);
    endfunction

    task automatic model_reset();
        m_init = 0;
        for (int m = 0; m < 2; m++) begin
            m_ghr[m] = 0;
            m_sl[m] = 0; m_su[m] = 0; m_sm[m] = 0;
            for (int i = 0; i < 64; i++) begin
                m_cnt[m][i] = 1;
                m_val[m][i] = 1'b0;
                m_tag[m][i] = 0;
                m_tgt[m][i] = '0;
            end
        end
    endtask

    task automatic model_pred(input int m, output bit h, output bit t,
                              output logic [31:0] tg);
        int b;
        b  = base_of(lpc);
        h  = (m_init >= 64) && m_val[m][b] && (m_tag[m][b] == tag_of(lpc));
        t  = h && (m_cnt[m][pidx(m, lpc, m_ghr[m])] >= 2);
        tg = t ? m_tgt[m][b] : lpc + 32'd4;
    endtask

    task automatic model_edge();
        bit h, t;
        logic [31:0] tg;
        int i, b, g;
        if (m_init < 64) begin
            m_init++;
            return;
        end
        for (int m = 0; m < 2; m++) begin
            model_pred(m, h, t, tg);
            g = m_ghr[m];
            if (lv) m_sl[m]++;
            if (uv && um) g = ((int'(ughr) * 2) + int'(ut)) % 64;
            else if (lv && h) g = ((m_ghr[m] * 2) + int'(t)) % 64;
            if (uv) begin
                m_su[m]++;
                if (um) m_sm[m]++;
                i = pidx(m, upc, int'(ughr));
                if (ut) m_cnt[m][i] = (m_cnt[m][i] == 3) ? 3 : m_cnt[m][i] + 1;
                else    m_cnt[m][i] = (m_cnt[m][i] == 0) ? 0 : m_cnt[m][i] - 1;
                if (ut) begin
                    b = base_of(upc);
                    m_val[m][b] = 1'b1;
                    m_tag[m][b] = tag_of(upc);
                    m_tgt[m][b] = utgt;
                end
            end
            m_ghr[m] = g;
        end
    endtask

    task automatic chk_dut(input int m, input logic h, input logic t,
                           input logic [31:0] tg, input logic [5:0] g);
        bit eh, et;
        logic [31:0] etg;
        model_pred(m, eh, et, etg);
        chk($sformatf("d%0d_hit", m), 64'(h), 64'(eh));
        chk($sformatf("d%0d_taken", m), 64'(t), 64'(et));
        chk($sformatf("d%0d_target", m), 64'(tg), 64'(etg));
        chk($sformatf("d%0d_ghr", m), 64'(g), 64'(m_ghr[m]));
    endtask

    task automatic cyc();
        @(negedge clk);
        chk("ready0", 64'(rdy0), 64'(m_init >= 64));
        chk("ready1", 64'(rdy1), 64'(m_init >= 64));
        chk_dut(0, bi0.pred_hit, bi0.pred_taken, bi0.pred_target, bi0.pred_ghr);
        chk_dut(1, bi1.pred_hit, bi1.pred_taken, bi1.pred_target, bi1.pred_ghr);
`ifdef BP_STATS_EN
        chk("stat_lk0", 64'(sl0), 64'(m_sl[0]));
        chk("stat_up1", 64'(su1), 64'(m_su[1]));
        chk("stat_mp1", 64'(sm1), 64'(m_sm[1]));
`endif
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic lv_, input logic [31:0] lpc_,
                          input logic uv_, input logic [31:0] upc_,
                          input logic ut_, input logic [31:0] utgt_,
                          input logic um_, input logic [5:0] ughr_);
        lv = lv_; lpc = lpc_; uv = uv_; upc = upc_;
        ut = ut_; utgt = utgt_; um = um_; ughr = ughr_;
    endtask

    function automatic logic [31:0] pick_pc();
        logic [31:0] pool [6];
        int k;
        pool = '{32'h100, 32'h104, 32'h108, 32'h200, 32'h300, 32'h10c};
        k = int'($urandom_range(0, 6));
        return (k == 6) ? ($urandom & 32'hffff_fffc) : pool[k];
    endfunction

    initial begin
        set_in(0, 32'h100, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(rdy0), 64'd0);
        chk("rst_hit", 64'(bi0.pred_hit), 64'd0);
        chk("rst_target", 64'(bi0.pred_target), 64'h104);
        chk("rst_ghr", 64'(bi1.pred_ghr), 64'd0);

        rst_n = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            if (k == 10) set_in(1, 32'h300, 1, 32'h300, 1, 32'h400, 1, 0);
            else         set_in(0, 32'h100, 0, 0, 0, 0, 0, 0);
            cyc();
            if (k == 63) chk("ready_at_63", 64'(rdy0), 64'd0);
        end
        chk("ready_at_64", 64'(rdy0), 64'd1);

        set_in(0, 32'h300, 0, 0, 0, 0, 0, 0);
        #1;
        chk("init_ignores_upd", 64'(bi0.pred_hit), 64'd0);

        repeat (2) begin
            set_in(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 0);
            cyc();
        end
        set_in(0, 32'h100, 0, 0, 0, 0, 0, 0);
        #1;
        chk("train_hit", 64'(bi0.pred_hit), 64'd1);
        chk("train_taken", 64'(bi0.pred_taken), 64'd1);
        chk("train_target", 64'(bi0.pred_target), 64'h200);

        set_in(0, 32'h200, 0, 0, 0, 0, 0, 0);
        #1;
        chk("alias_hit", 64'(bi0.pred_hit), 64'd0);
        chk("alias_target", 64'(bi0.pred_target), 64'h204);
        cyc();

        repeat (3) begin
            set_in(0, 32'h100, 1, 32'h100, 0, 0, 0, 0);
            cyc();
        end
        set_in(0, 32'h100, 0, 0, 0, 0, 0, 0);
        #1;
        chk("nt_hit", 64'(bi0.pred_hit), 64'd1);
        chk("nt_taken", 64'(bi0.pred_taken), 64'd0);
        chk("nt_target", 64'(bi0.pred_target), 64'h104);

        repeat (5) begin
            set_in(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 0);
            cyc();
        end
        set_in(0, 32'h100, 1, 32'h100, 0, 0, 0, 0);
        cyc();
        set_in(0, 32'h100, 0, 0, 0, 0, 0, 0);
        #1;
        chk("sat_one_nt", 64'(bi0.pred_taken), 64'd1);
        set_in(0, 32'h100, 1, 32'h100, 0, 0, 0, 0);
        cyc();
        set_in(0, 32'h100, 0, 0, 0, 0, 0, 0);
        #1;
        chk("sat_two_nt", 64'(bi0.pred_taken), 64'd0);

        set_in(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 0);
        #1;
        chk("same_cyc_pre", 64'(bi0.pred_taken), 64'd0);
        cyc();
        set_in(0, 32'h100, 0, 0, 0, 0, 0, 0);
        #1;
        chk("same_cyc_post", 64'(bi0.pred_taken), 64'd1);

        set_in(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 6'd1);
        cyc();
        set_in(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 6'd3);
        cyc();
        repeat (3) begin
            set_in(1, 32'h100, 0, 0, 0, 0, 0, 0);
            cyc();
        end
        chk("gshare_ghr7", 64'(bi1.pred_ghr), 64'h07);
        set_in(1, 32'h100, 1, 32'h100, 0, 32'h0, 1, 6'd1);
        cyc();
        chk("gshare_recover", 64'(bi1.pred_ghr), 64'h02);

        for (int n = 0; n < 400; n++) begin
            set_in(1'($urandom_range(0, 1)), pick_pc(),
                   1'($urandom_range(0, 1)), pick_pc(),
                   1'($urandom_range(0, 1)), $urandom & 32'hffff_fffc,
                   ($urandom_range(0, 3) == 0), 6'($urandom_range(0, 63)));
            cyc();
        end

        set_in(1, 32'h100, 1, 32'h100, 1, 32'h200, 0, 0);
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_ready", 64'(rdy0), 64'd0);
        chk("midrst_ghr", 64'(bi1.pred_ghr), 64'd0);
        chk("midrst_hit", 64'(bi0.pred_hit), 64'd0);
`ifdef BP_STATS_EN
        chk("midrst_stat_lk", 64'(sl0), 64'd0);
        chk("midrst_stat_up", 64'(su1), 64'd0);
        chk("midrst_stat_mp", 64'(sm1), 64'd0);
`endif
        set_in(0, 32'h100, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (64) cyc();
        chk("reinit_ready", 64'(rdy1), 64'd1);
        chk("reinit_miss0", 64'(bi0.pred_hit), 64'd0);
        chk("reinit_miss1", 64'(bi1.pred_hit), 64'd0);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
